// File: rtl/sync_ram_p.sv
// Parametrised single-port synchronous RAM with a clear sweep and a registered read path.
// Optional macro SYNC_RAM_OUT_REG_EN adds a second rdata/rvalid pipeline stage (2-cycle read latency).
module sync_ram_p #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clear,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              state_dbg
);
    // Handshake: enable/clear are accepted on any rising edge where busy=0 and
    // ignored otherwise; rvalid is a one-cycle strobe with no back-pressure,
    // and rdata holds its last value whenever rvalid=0.

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_addr   = address;
        mem_wdata  = wdata;
        rd_en      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_addr   = clr_addr_q;
                mem_wdata  = INIT_VAL;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // clear wins over a same-edge access, which is dropped
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (enable) begin
                    mem_we = we;
                    rd_en  = ~we;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // Array has no reset; only the sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rvalid_q   <= rd_en;
            if (rd_en) begin
                rdata_q <= mem[address];
            end
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign state_dbg = state_q;

`ifdef SYNC_RAM_OUT_REG_EN
    logic              squash;
    logic [DATA_W-1:0] rdata_p;
    logic              rvalid_p;

    // A clear accepted this edge kills the read sitting in the first stage.
    assign squash = (state_q == ST_READY) && clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_p  <= '0;
            rvalid_p <= 1'b0;
        end else begin
            rvalid_p <= rvalid_q && !squash;
            if (rvalid_q && !squash) begin
                rdata_p <= rdata_q;
            end
        end
    end

    assign rdata  = rdata_p;
    assign rvalid = rvalid_p;
`else
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sync_ram_p.sv
// Self-checking bench for sync_ram_p: directed steps plus random traffic against a behavioural model.
module tb_sync_ram_p;
    localparam int                DATA_W   = 8;
    localparam int                ADDR_W   = 4;
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] INIT_VAL = 8'hA5;
`ifdef SYNC_RAM_OUT_REG_EN
    localparam int                LAT      = 2;
`else
    localparam int                LAT      = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              clear;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              state_dbg;

    sync_ram_p #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .INIT_VAL(INIT_VAL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .we       (we),
        .address  (address),
        .wdata    (wdata),
        .clear    (clear),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: memory contents, sweep edges left, read-result delay line
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                sweep_left;
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    int                errors = 0;
    int                checks = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, sweep_left > 0});
        check({tag, ".rvalid"}, {7'd0, rvalid}, {7'd0, m_rvalid});
        check({tag, ".rdata"}, rdata, m_rdata);
    endtask

    task automatic model_reset();
        sweep_left = DEPTH;
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
        m_rdata  = '0;
        m_rvalid = 1'b0;
    endtask

    // driver: one rising edge with the current inputs, model update, then compare
    task automatic tick(input string tag);
        logic [DATA_W:0] e;
        logic [DATA_W:0] o;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (sweep_left > 0) begin
                m_mem[DEPTH - sweep_left] = INIT_VAL;
                sweep_left--;
            end else if (clear) begin
                foreach (exp_q[i]) exp_q[i][DATA_W] = 1'b0;
                sweep_left = DEPTH;
            end else if (enable && we) begin
                m_mem[address] = wdata;
            end else if (enable) begin
                e = {1'b1, m_mem[address]};
            end
            exp_q.push_back(e);
            o = exp_q.pop_front();
            m_rvalid = o[DATA_W];
            if (o[DATA_W]) m_rdata = o[DATA_W-1:0];
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        enable = 1'b0;
        we     = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic assert_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
    endtask

    task automatic do_read(input int a, input string tag);
        enable  = 1'b1;
        we      = 1'b0;
        address = a[ADDR_W-1:0];
        tick(tag);
    endtask

    task automatic do_write(input int a, input logic [DATA_W-1:0] d, input string tag);
        enable  = 1'b1;
        we      = 1'b1;
        address = a[ADDR_W-1:0];
        wdata   = d;
        tick(tag);
    endtask

    task automatic drain(input int n, input string tag);
        idle_inputs();
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    logic [DATA_W-1:0] fib [6];

    initial begin
        rst_n   = 1'b1;
        address = '0;
        wdata   = '0;
        idle_inputs();
        model_reset();
        #2;
        assert_reset("reset_async");
        tick("reset_hold0");
        tick("reset_hold1");
        rst_n = 1'b1;

        // sweep: write and clear attempts while busy must be ignored
        for (int k = 1; k <= DEPTH; k++) begin
            enable  = 1'b1;
            we      = 1'b1;
            address = 4'd3;
            wdata   = 8'h77;
            clear   = (k == 5);
            tick("sweep");
        end
        idle_inputs();

        for (int a = 0; a < DEPTH; a++) do_read(a, "read_init");
        drain(LAT + 1, "read_init_tail");

        fib[0] = 8'h01; fib[1] = 8'h02; fib[2] = 8'h03;
        fib[3] = 8'h05; fib[4] = 8'h08; fib[5] = 8'h0D;
        for (int a = 0; a < 6; a++) do_write(a, fib[a], "fib_wr");
        for (int a = 0; a < 6; a++) do_read(a, "fib_rd");
        drain(LAT + 1, "fib_tail");

        // read then clear+read: clear wins, pipelined read is dropped
        do_read(4, "pre_clear_rd");
        clear = 1'b1;
        do_read(2, "clear_with_rd");
        idle_inputs();
        for (int k = 0; k < DEPTH; k++) tick("clear_sweep");
        do_read(2, "post_clear_rd");
        drain(LAT + 1, "post_clear_tail");

        do_write(5, 8'h0D, "wr5");
        do_read(5, "rd5");
        do_write(9, 8'h3C, "wr9");
        do_read(9, "rd9_after_wr");
        drain(LAT + 1, "wr_rd_tail");

        // reset at sweep edge 7
        clear = 1'b1;
        tick("clear2");
        idle_inputs();
        for (int k = 0; k < 7; k++) tick("sweep_pre_rst");
        assert_reset("mid_sweep_rst");
        tick("mid_sweep_rst_edge");
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) tick("sweep_restart");

        // reset during a write access
        do_read(1, "pre_rst_rd");
        enable  = 1'b1;
        we      = 1'b1;
        address = 4'd6;
        wdata   = 8'hEE;
        assert_reset("mid_access_rst");
        tick("mid_access_rst_edge");
        idle_inputs();
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) tick("sweep_after_rst");
        do_read(6, "rd6_after_rst");
        drain(LAT + 1, "rst_tail");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            enable  = ($urandom_range(0, 3) != 0);
            we      = $urandom_range(0, 1) == 1;
            address = ADDR_W'($urandom_range(0, DEPTH - 1));
            wdata   = DATA_W'($urandom);
            clear   = ($urandom_range(0, 39) == 0);
            tick("random");
        end
        drain(LAT + 1, "random_tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
